// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, ALU op codes, fetch FSM states and the
// jump-target select encoding used by both the control unit and fetch.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        FULL   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    // jumpAddr encoding: next sequential PC, j/jal, jr, taken branch
    localparam logic [1:0] JSEL_NPC = 2'b00;
    localparam logic [1:0] JSEL_J   = 2'b01;
    localparam logic [1:0] JSEL_JR  = 2'b10;
    localparam logic [1:0] JSEL_BR  = 2'b11;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: icache request/response, decode handshake, redirect
// and halt inputs. With FETCH_PERF_CNT_EN defined the bundle also carries
// the fetch/redirect performance counters.
interface fetch_unit_if;
    import cpu_types_pkg::*;

    logic        ihit;
    word_t       imemload;
    logic        imemREN;
    word_t       imemaddr;
    word_t       instr;
    word_t       npc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [1:0]  jumpAddr;
    word_t       redirect_npc;
    logic [25:0] immJ;
    logic [15:0] imm;
    word_t       rdat1;
    logic        halt;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    word_t       fetch_count;
    word_t       redirect_count;
`endif

    modport fu (
        input  ihit, imemload, instr_ready, redirect, jumpAddr,
               redirect_npc, immJ, imm, rdat1, halt,
`ifdef FETCH_PERF_CNT_EN
        output fetch_count, redirect_count,
`endif
        output imemREN, imemaddr, instr, npc, instr_valid, halted
    );

    modport tb (
        output ihit, imemload, instr_ready, redirect, jumpAddr,
               redirect_npc, immJ, imm, rdat1, halt,
`ifdef FETCH_PERF_CNT_EN
        input  fetch_count, redirect_count,
`endif
        input  imemREN, imemaddr, instr, npc, instr_valid, halted
    );

endinterface

// File: rtl/fetch_target.sv
// Redirect target computation for j/jal, jr and taken branches.
// All arithmetic wraps mod 2^32.
module fetch_target
    import cpu_types_pkg::*;
(
    input  logic [1:0]  jump_addr,
    input  word_t       redirect_npc,
    input  logic [25:0] imm_j,
    input  logic [15:0] imm,
    input  word_t       rdat1,
    output word_t       target
);

    // Select the target for the requested transfer kind
    always_comb begin
        target = redirect_npc;
        case (jump_addr)
            JSEL_J:   target = {redirect_npc[31:28], imm_j, 2'b00};
            JSEL_JR:  target = rdat1;
            JSEL_BR:  target = redirect_npc + {{14{imm[15]}}, imm, 2'b00};
            default:  target = redirect_npc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, icache request, one-word buffer toward
// decode, redirect and halt handling.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count/redirect_count.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic     CLK,
    input  logic     nRST,
    fetch_unit_if.fu fuif
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        instr_q, instr_d;
    word_t        npc_q, npc_d;
    word_t        target_s;
    logic         redirect_apply_s;
    logic         fetch_accept_s;

    fetch_target u_target (
        .jump_addr    (fuif.jumpAddr),
        .redirect_npc (fuif.redirect_npc),
        .imm_j        (fuif.immJ),
        .imm          (fuif.imm),
        .rdat1        (fuif.rdat1),
        .target       (target_s)
    );

    // Next-state logic; halt beats redirect, redirect beats hit/transfer
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        instr_d          = instr_q;
        npc_d            = npc_q;
        redirect_apply_s = fuif.redirect && (fuif.jumpAddr != JSEL_NPC)
                           && (state_q != HALTED) && !fuif.halt;
        fetch_accept_s   = 1'b0;
        if (fuif.halt) begin
            state_d = HALTED;
        end else if (redirect_apply_s) begin
            // any buffered word or same-cycle hit is dropped
            pc_d    = target_s;
            state_d = FETCH;
        end else begin
            case (state_q)
                IDLE:   state_d = FETCH;
                FETCH: begin
                    if (fuif.ihit) begin
                        fetch_accept_s = 1'b1;
                        instr_d        = fuif.imemload;
                        npc_d          = pc_q + 32'd4;
                        pc_d           = pc_q + 32'd4;
                        state_d        = FULL;
                    end else begin
                        state_d = FETCH;
                    end
                end
                FULL: begin
                    if (fuif.instr_ready) begin
                        state_d = FETCH;
                    end else begin
                        state_d = FULL;
                    end
                end
                HALTED: state_d = HALTED;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, PC and buffered word registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            pc_q    <= PC_INIT;
            instr_q <= 32'h0000_0000;
            npc_q   <= PC_INIT + 32'd4;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
        end
    end

    assign fuif.imemREN     = (state_q == FETCH);
    assign fuif.imemaddr    = pc_q;
    assign fuif.instr       = instr_q;
    assign fuif.npc         = npc_q;
    assign fuif.instr_valid = (state_q == FULL);
    assign fuif.halted      = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
    word_t fetch_count_q, fetch_count_d;
    word_t redirect_count_q, redirect_count_d;

    // Counter increments; accepted hits and applied redirects never occur in HALTED
    always_comb begin
        fetch_count_d    = fetch_count_q;
        redirect_count_d = redirect_count_q;
        if (fetch_accept_s) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
        if (redirect_apply_s) begin
            redirect_count_d = redirect_count_q + 32'd1;
        end else begin
            redirect_count_d = redirect_count_q;
        end
    end

    // Performance counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_count_q    <= 32'd0;
            redirect_count_q <= 32'd0;
        end else begin
            fetch_count_q    <= fetch_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign fuif.fetch_count    = fetch_count_q;
    assign fuif.redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   total;
    int   bad;

    fetch_unit_if fuif();

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .fuif (fuif)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST      = 1'b0;
        fuif.ihit = 1'b1;
        fuif.imemload = 32'hBAD0_BAD0;
        step();
        step();
        total++; if (fuif.imemREN !== 1'b0) begin bad++; $display("FAIL rst_ren got=%b exp=0", fuif.imemREN); end
        total++; if (fuif.imemaddr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", fuif.imemaddr); end
        total++; if (fuif.instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", fuif.instr); end
        total++; if (fuif.npc !== 32'h4) begin bad++; $display("FAIL rst_npc got=%h exp=4", fuif.npc); end
        total++; if (fuif.instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", fuif.instr_valid); end
        total++; if (fuif.halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", fuif.halted); end
        nRST = 1'b1;
        step();
        // IDLE -> FETCH, the hit seen in IDLE is ignored
        total++; if (fuif.imemREN !== 1'b1) begin bad++; $display("FAIL idle_to_fetch got=%b exp=1", fuif.imemREN); end
        total++; if (fuif.instr_valid !== 1'b0) begin bad++; $display("FAIL idle_hit_ignored got=%b exp=0", fuif.instr_valid); end
        total++; if (fuif.imemaddr !== 32'h0) begin bad++; $display("FAIL first_addr got=%h exp=0", fuif.imemaddr); end
        fuif.ihit = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        fuif.ihit = 1'b1;
        fuif.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = 32'(i) << 2;
            fuif.imemload = 32'h1000_0000 + 32'(i);
            total++; if (fuif.imemREN !== 1'b1) begin bad++; $display("FAIL seq_ren got=%b exp=1", fuif.imemREN); end
            total++; if (fuif.imemaddr !== e) begin bad++; $display("FAIL seq_addr got=%h exp=%h", fuif.imemaddr, e); end
            step();
            total++; if (fuif.instr_valid !== 1'b1) begin bad++; $display("FAIL seq_valid got=%b exp=1", fuif.instr_valid); end
            total++; if (fuif.instr !== 32'h1000_0000 + 32'(i)) begin bad++; $display("FAIL seq_instr got=%h exp=%h", fuif.instr, 32'h1000_0000 + 32'(i)); end
            total++; if (fuif.npc !== e + 32'd4) begin bad++; $display("FAIL seq_npc got=%h exp=%h", fuif.npc, e + 32'd4); end
            total++; if (fuif.imemREN !== 1'b0) begin bad++; $display("FAIL seq_full_ren got=%b exp=0", fuif.imemREN); end
            step();
        end
        fuif.ihit = 1'b0;
        fuif.instr_ready = 1'b0;
    endtask

    task automatic test_stall();
        fuif.ihit = 1'b1;
        fuif.imemload = 32'hCAFE_0001;
        step();
        fuif.imemload = 32'h5555_AAAA;
        for (int i = 0; i < 5; i++) begin
            total++; if (fuif.instr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", fuif.instr_valid); end
            total++; if (fuif.instr !== 32'hCAFE_0001) begin bad++; $display("FAIL stall_instr got=%h exp=cafe0001", fuif.instr); end
            total++; if (fuif.npc !== 32'h10) begin bad++; $display("FAIL stall_npc got=%h exp=10", fuif.npc); end
            total++; if (fuif.imemREN !== 1'b0) begin bad++; $display("FAIL stall_ren got=%b exp=0", fuif.imemREN); end
            step();
        end
        fuif.instr_ready = 1'b1;
        step();
        total++; if (fuif.imemREN !== 1'b1) begin bad++; $display("FAIL resume_ren got=%b exp=1", fuif.imemREN); end
        total++; if (fuif.imemaddr !== 32'h10) begin bad++; $display("FAIL resume_addr got=%h exp=10", fuif.imemaddr); end
        total++; if (fuif.instr_valid !== 1'b0) begin bad++; $display("FAIL resume_valid got=%b exp=0", fuif.instr_valid); end
        fuif.ihit = 1'b0;
        fuif.instr_ready = 1'b0;
    endtask

    task automatic test_jump();
        fuif.redirect = 1'b1;
        fuif.jumpAddr = 2'b01;
        fuif.redirect_npc = 32'h0000_0044;
        fuif.immJ = 26'h100;
        step();
        fuif.redirect = 1'b0;
        total++; if (fuif.imemaddr !== 32'h0000_0400) begin bad++; $display("FAIL jump_addr got=%h exp=400", fuif.imemaddr); end
        total++; if (fuif.imemREN !== 1'b1) begin bad++; $display("FAIL jump_ren got=%b exp=1", fuif.imemREN); end
    endtask

    task automatic test_branch_jr();
        fuif.redirect = 1'b1;
        fuif.jumpAddr = 2'b11;
        fuif.redirect_npc = 32'h0000_0100;
        fuif.imm = 16'hFFFE;
        step();
        total++; if (fuif.imemaddr !== 32'h0000_00F8) begin bad++; $display("FAIL br_addr got=%h exp=f8", fuif.imemaddr); end
        // same branch with a hit in the same cycle: the hit word is dropped
        fuif.ihit = 1'b1;
        fuif.imemload = 32'hDEAD_BEEF;
        step();
        fuif.redirect = 1'b0;
        fuif.ihit = 1'b0;
        total++; if (fuif.imemaddr !== 32'h0000_00F8) begin bad++; $display("FAIL br_hit_addr got=%h exp=f8", fuif.imemaddr); end
        total++; if (fuif.imemREN !== 1'b1) begin bad++; $display("FAIL br_hit_ren got=%b exp=1", fuif.imemREN); end
        for (int i = 0; i < 2; i++) begin
            total++; if (fuif.instr_valid !== 1'b0) begin bad++; $display("FAIL br_hit_dropped got=%b exp=0", fuif.instr_valid); end
            step();
        end
        fuif.ihit = 1'b1;
        fuif.imemload = 32'h1111_2222;
        step();
        fuif.ihit = 1'b0;
        total++; if (fuif.instr !== 32'h1111_2222) begin bad++; $display("FAIL br_instr got=%h exp=11112222", fuif.instr); end
        total++; if (fuif.npc !== 32'h0000_00FC) begin bad++; $display("FAIL br_npc got=%h exp=fc", fuif.npc); end
        // jr while a word is buffered: word dropped, fetch from rdat1
        fuif.redirect = 1'b1;
        fuif.jumpAddr = 2'b10;
        fuif.rdat1 = 32'h0000_2000;
        step();
        total++; if (fuif.imemaddr !== 32'h0000_2000) begin bad++; $display("FAIL jr_addr got=%h exp=2000", fuif.imemaddr); end
        total++; if (fuif.instr_valid !== 1'b0) begin bad++; $display("FAIL jr_drop got=%b exp=0", fuif.instr_valid); end
        total++; if (fuif.imemREN !== 1'b1) begin bad++; $display("FAIL jr_ren got=%b exp=1", fuif.imemREN); end
        // redirect with jumpAddr 00 is ignored; the hit is accepted
        fuif.jumpAddr = 2'b00;
        fuif.rdat1 = 32'h0000_9000;
        fuif.ihit = 1'b1;
        fuif.imemload = 32'h0000_3333;
        step();
        fuif.redirect = 1'b0;
        fuif.ihit = 1'b0;
        total++; if (fuif.instr_valid !== 1'b1) begin bad++; $display("FAIL nosel_valid got=%b exp=1", fuif.instr_valid); end
        total++; if (fuif.instr !== 32'h0000_3333) begin bad++; $display("FAIL nosel_instr got=%h exp=3333", fuif.instr); end
        total++; if (fuif.imemaddr !== 32'h0000_2004) begin bad++; $display("FAIL nosel_addr got=%h exp=2004", fuif.imemaddr); end
    endtask

    task automatic test_halt();
        fuif.halt = 1'b1;
        fuif.redirect = 1'b1;
        fuif.jumpAddr = 2'b01;
        fuif.redirect_npc = 32'h0000_0044;
        fuif.immJ = 26'h100;
        step();
        fuif.halt = 1'b0;
        fuif.redirect = 1'b0;
        total++; if (fuif.halted !== 1'b1) begin bad++; $display("FAIL halt_halted got=%b exp=1", fuif.halted); end
        total++; if (fuif.instr_valid !== 1'b0) begin bad++; $display("FAIL halt_valid got=%b exp=0", fuif.instr_valid); end
        total++; if (fuif.imemaddr !== 32'h0000_2004) begin bad++; $display("FAIL halt_no_redirect got=%h exp=2004", fuif.imemaddr); end
        fuif.ihit = 1'b1;
        fuif.instr_ready = 1'b1;
        fuif.redirect = 1'b1;
        for (int i = 0; i < 20; i++) begin
            total++; if (fuif.imemREN !== 1'b0 || fuif.halted !== 1'b1) begin bad++; $display("FAIL halt_hold ren=%b halted=%b exp ren=0 halted=1", fuif.imemREN, fuif.halted); end
            step();
        end
        fuif.redirect = 1'b0;
        nRST = 1'b0;
        #1;
        total++; if (fuif.imemaddr !== 32'h0) begin bad++; $display("FAIL halt_rst_addr got=%h exp=0", fuif.imemaddr); end
        total++; if (fuif.halted !== 1'b0) begin bad++; $display("FAIL halt_rst_halted got=%b exp=0", fuif.halted); end
        total++; if (fuif.npc !== 32'h4) begin bad++; $display("FAIL halt_rst_npc got=%h exp=4", fuif.npc); end
        step();
        nRST = 1'b1;
        step();
        total++; if (fuif.imemREN !== 1'b1) begin bad++; $display("FAIL post_rst_ren got=%b exp=1", fuif.imemREN); end
        total++; if (fuif.instr_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b exp=0", fuif.instr_valid); end
        fuif.ihit = 1'b0;
        fuif.instr_ready = 1'b0;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        total++; if (fuif.fetch_count !== 32'd0) begin bad++; $display("FAIL perf_rst_fetch got=%0d exp=0", fuif.fetch_count); end
        total++; if (fuif.redirect_count !== 32'd0) begin bad++; $display("FAIL perf_rst_redir got=%0d exp=0", fuif.redirect_count); end
        fuif.instr_ready = 1'b1;
        fuif.ihit = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            step();
        end
        fuif.ihit = 1'b0;
        fuif.redirect = 1'b1;
        fuif.jumpAddr = 2'b01;
        fuif.redirect_npc = 32'h0;
        fuif.immJ = 26'h0;
        step();
        step();
        fuif.redirect = 1'b0;
        total++; if (fuif.fetch_count !== 32'd10) begin bad++; $display("FAIL perf_fetch got=%0d exp=10", fuif.fetch_count); end
        total++; if (fuif.redirect_count !== 32'd2) begin bad++; $display("FAIL perf_redir got=%0d exp=2", fuif.redirect_count); end
        fuif.halt = 1'b1;
        step();
        fuif.halt = 1'b0;
        fuif.ihit = 1'b1;
        fuif.redirect = 1'b1;
        step();
        step();
        fuif.ihit = 1'b0;
        fuif.redirect = 1'b0;
        total++; if (fuif.fetch_count !== 32'd10 || fuif.redirect_count !== 32'd2) begin bad++; $display("FAIL perf_freeze fetch=%0d redir=%0d exp 10 2", fuif.fetch_count, fuif.redirect_count); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        nRST  = 1'b0;
        fuif.ihit = 1'b0;
        fuif.imemload = 32'h0;
        fuif.instr_ready = 1'b0;
        fuif.redirect = 1'b0;
        fuif.jumpAddr = 2'b00;
        fuif.redirect_npc = 32'h0;
        fuif.immJ = 26'h0;
        fuif.imm = 16'h0;
        fuif.rdat1 = 32'h0;
        fuif.halt = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_branch_jr();
        test_halt();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
